// File: rtl/minirisc_pkg.sv
// -----------------------------------------------------------------------------
// minirisc_pkg
// Shared constants and types for the register-file write-back path.
//   REG_ADDR_W : register address width (16 registers)
//   DATA_W     : register data width
//   CNT_W      : width of the load wait-state counter
//   wb_state_t : write-back controller states
// -----------------------------------------------------------------------------
package minirisc_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 8;
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      WB      = 2'd2
   } wb_state_t;

endpackage

// File: rtl/reg_wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// reg_wb_timeout_cnt
// Saturating 8-bit wait-state counter used while a load is outstanding.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (takes priority over i_en)
//   i_en       : count this cycle
//   o_match    : this cycle is the LOAD_TIMEOUT-th counted cycle
//                (never asserted when LOAD_TIMEOUT == 0)
// -----------------------------------------------------------------------------
module reg_wb_timeout_cnt
   import minirisc_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_match
);

   // LOAD_TIMEOUT is limited to 0..255, so 9 bits hold it and cnt+1 exactly.
   localparam logic [CNT_W:0] TO_W = (CNT_W+1)'(LOAD_TIMEOUT);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W:0]   w_cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds the number of already completed wait cycles, so the current
   // cycle is number r_cnt+1; the abort fires in cycle LOAD_TIMEOUT itself.
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign o_match   = (TO_W != '0) && (w_cnt_inc == TO_W);

endmodule

// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
// Write-back controller in front of the 16 x 8 register file. Owns the shared
// X address, write enable and write data; sequences single-cycle ALU results
// and variable-latency data-memory loads (with timeout) into the file.
//
// Handshake: alu_valid / ld_start are single-cycle pulses accepted only in
// IDLE (upstream must hold while stall=1, otherwise the request is dropped);
// mem_rd_valid is sampled only in LD_WAIT and needs no ready.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   dec_addr_x        : decoder X read address (used when not writing)
//   alu_valid/addr/data : ALU write request
//   ld_start/ld_addr  : load issued, destination register
//   mem_rd_valid/data : load return data
//   rf_addr_x         : register file X address (write addr while writing)
//   rf_write_en       : register file write enable (registered)
//   rf_wr_data_x      : register file write data (registered)
//   stall             : hold decode/fetch
//   bus_err           : sticky load timeout flag (cleared by reset only)
//   dbg_state         : current controller state
// Optional (macro REG_WB_FWD_EN):
//   dec_addr_y        : decoder Y read address
//   fwd_x, fwd_y      : operand X/Y matches the register written this cycle
//   fwd_data          : value being written this cycle
// -----------------------------------------------------------------------------
module reg_wb_ctrl
   import minirisc_pkg::*;
#(
   parameter int unsigned LOAD_TIMEOUT = 15   // 0 disables; legal 0..255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] dec_addr_x,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  ld_start,
   input  logic [REG_ADDR_W-1:0] ld_addr,
   input  logic                  mem_rd_valid,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic [REG_ADDR_W-1:0] rf_addr_x,
   output logic                  rf_write_en,
   output logic [DATA_W-1:0]     rf_wr_data_x,
   output logic                  stall,
   output logic                  bus_err,
`ifdef REG_WB_FWD_EN
   input  logic [REG_ADDR_W-1:0] dec_addr_y,
   output logic                  fwd_x,
   output logic                  fwd_y,
   output logic [DATA_W-1:0]     fwd_data,
`endif
   output wb_state_t             dbg_state
);

   wb_state_t             r_state,   w_state_nxt;
   logic                  r_we,      w_we_nxt;
   logic [REG_ADDR_W-1:0] r_wb_addr, w_wb_addr_nxt;
   logic [DATA_W-1:0]     r_wr_data, w_wr_data_nxt;
   logic [REG_ADDR_W-1:0] r_ld_dst,  w_ld_dst_nxt;
   logic                  r_bus_err, w_bus_err_nxt;
   logic                  w_cnt_clr;
   logic                  w_cnt_en;
   logic                  w_timeout;

   reg_wb_timeout_cnt #(
      .LOAD_TIMEOUT (LOAD_TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_match (w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         r_wb_addr <= '0;
         r_wr_data <= '0;
         r_ld_dst  <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_we      <= w_we_nxt;
         r_wb_addr <= w_wb_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_ld_dst  <= w_ld_dst_nxt;
         r_bus_err <= w_bus_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_we_nxt      = 1'b0;
      w_wb_addr_nxt = r_wb_addr;
      w_wr_data_nxt = r_wr_data;
      w_ld_dst_nxt  = r_ld_dst;
      w_bus_err_nxt = r_bus_err;
      w_cnt_clr     = 1'b0;
      w_cnt_en      = 1'b0;

      unique case (r_state)
         IDLE: begin
            // ALU write and load launch are independent; when both arrive
            // together the ALU write goes out now and the load writes later,
            // so a shared destination ends up holding the load data.
            if (alu_valid) begin
               w_we_nxt      = 1'b1;
               w_wb_addr_nxt = alu_addr;
               w_wr_data_nxt = alu_data;
            end
            if (ld_start) begin
               w_ld_dst_nxt = ld_addr;
               w_cnt_clr    = 1'b1;
               w_state_nxt  = LD_WAIT;
            end
         end
         LD_WAIT: begin
            w_cnt_en = 1'b1;
            // Data arriving in the timeout cycle still completes the load.
            if (mem_rd_valid) begin
               w_we_nxt      = 1'b1;
               w_wb_addr_nxt = r_ld_dst;
               w_wr_data_nxt = mem_rd_data;
               w_state_nxt   = WB;
            end else if (w_timeout) begin
               w_bus_err_nxt = 1'b1;
               w_state_nxt   = IDLE;
            end
         end
         WB: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rf_addr_x    = r_we ? r_wb_addr : dec_addr_x;
   assign rf_write_en  = r_we;
   assign rf_wr_data_x = r_wr_data;
   assign stall        = r_we | (r_state == LD_WAIT);
   assign bus_err      = r_bus_err;
   assign dbg_state    = r_state;

`ifdef REG_WB_FWD_EN
   assign fwd_x    = r_we && (r_wb_addr == dec_addr_x);
   assign fwd_y    = r_we && (r_wb_addr == dec_addr_y);
   assign fwd_data = r_wr_data;
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;
   import minirisc_pkg::*;

   localparam int unsigned TO = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] dec_addr_x;
   logic       alu_valid;
   logic [3:0] alu_addr;
   logic [7:0] alu_data;
   logic       ld_start;
   logic [3:0] ld_addr;
   logic       mem_rd_valid;
   logic [7:0] mem_rd_data;
   logic [3:0] rf_addr_x;
   logic       rf_write_en;
   logic [7:0] rf_wr_data_x;
   logic       stall;
   logic       bus_err;
   wb_state_t  dbg_state;
`ifdef REG_WB_FWD_EN
   logic [3:0] dec_addr_y;
   logic       fwd_x;
   logic       fwd_y;
   logic [7:0] fwd_data;
`endif

   reg_wb_ctrl #(.LOAD_TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dec_addr_x   (dec_addr_x),
      .alu_valid    (alu_valid),
      .alu_addr     (alu_addr),
      .alu_data     (alu_data),
      .ld_start     (ld_start),
      .ld_addr      (ld_addr),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data),
      .rf_addr_x    (rf_addr_x),
      .rf_write_en  (rf_write_en),
      .rf_wr_data_x (rf_wr_data_x),
      .stall        (stall),
      .bus_err      (bus_err),
`ifdef REG_WB_FWD_EN
      .dec_addr_y   (dec_addr_y),
      .fwd_x        (fwd_x),
      .fwd_y        (fwd_y),
      .fwd_data     (fwd_data),
`endif
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // register file fed by the DUT's write port (cleared while in reset)
   logic [7:0] tb_rf [16];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) tb_rf[i] <= 8'h00;
      end else if (rf_write_en) begin
         tb_rf[rf_addr_x] <= rf_wr_data_x;
      end
   end

   // reference model: architectural register contents and sticky error
   logic [7:0] model_rf [16];
   logic       err_exp;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model_rf[i] = 8'h00;
      err_exp = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_we"},    32'(rf_write_en), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_addr"},  32'(rf_addr_x), 32'(dec_addr_x));
      chk({tag, "_err"},   32'(bus_err), 32'(err_exp));
      chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   // One transaction: optional ALU write and/or load that returns its data in
   // wait cycle w (w >= 1). A load needing more than TO cycles times out.
   task automatic run_op(input bit do_alu, input logic [3:0] aa, input logic [7:0] ad,
                         input bit do_ld, input logic [3:0] la, input int w,
                         input logic [7:0] ld_d);
      bit tmo;
      int lim;
      @(negedge clk);
      chk("req_while_stalled", 32'(stall), 32'd0);
      dec_addr_x = 4'($urandom_range(0, 15));
      alu_valid  = do_alu;
      alu_addr   = aa;
      alu_data   = ad;
      ld_start   = do_ld;
      ld_addr    = la;
      @(posedge clk); #1;
      if (do_alu) begin
         chk("alu_we",    32'(rf_write_en), 32'd1);
         chk("alu_addr",  32'(rf_addr_x), 32'(aa));
         chk("alu_data",  32'(rf_wr_data_x), 32'(ad));
         chk("alu_stall", 32'(stall), 32'd1);
         model_rf[aa] = ad;
      end
      @(negedge clk);
      alu_valid = 1'b0;
      ld_start  = 1'b0;
      alu_addr  = 4'($urandom_range(0, 15));
      ld_addr   = 4'($urandom_range(0, 15));
      if (do_ld) begin
         tmo = (TO != 0) && (w > int'(TO));
         lim = tmo ? int'(TO) : w;
         for (int k = 1; k <= lim; k++) begin
            chk("ldw_stall", 32'(stall), 32'd1);
            chk("ldw_we",    32'(rf_write_en), 32'((k == 1) && do_alu));
            mem_rd_valid = (k == w);
            mem_rd_data  = (k == w) ? ld_d : 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (k < lim) @(negedge clk);
         end
         if (tmo) begin
            err_exp = 1'b1;
            chk("tmo_we",    32'(rf_write_en), 32'd0);
            chk("tmo_stall", 32'(stall), 32'd0);
            chk("tmo_err",   32'(bus_err), 32'd1);
            chk("tmo_state", 32'(dbg_state), 32'(IDLE));
         end else begin
            chk("ld_we",    32'(rf_write_en), 32'd1);
            chk("ld_addr",  32'(rf_addr_x), 32'(la));
            chk("ld_data",  32'(rf_wr_data_x), 32'(ld_d));
            chk("ld_stall", 32'(stall), 32'd1);
            chk("ld_state", 32'(dbg_state), 32'(WB));
            model_rf[la] = ld_d;
         end
         @(negedge clk);
         mem_rd_valid = 1'b0;
      end
      @(posedge clk); #1;
      idle_check("after_op");
      if (do_alu) chk("rf_alu_reg", 32'(tb_rf[aa]), 32'(model_rf[aa]));
      if (do_ld)  chk("rf_ld_reg",  32'(tb_rf[la]), 32'(model_rf[la]));
   endtask

   initial begin
      int typ;
      int w;
      rst_n        = 1'b0;
      dec_addr_x   = 4'd0;
      alu_valid    = 1'b0;
      alu_addr     = 4'd0;
      alu_data     = 8'd0;
      ld_start     = 1'b0;
      ld_addr      = 4'd0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = 8'd0;
`ifdef REG_WB_FWD_EN
      dec_addr_y   = 4'd0;
`endif
      model_reset();
      #1;
      chk("rst_we",    32'(rf_write_en), 32'd0);
      chk("rst_data",  32'(rf_wr_data_x), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_err",   32'(bus_err), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // directed
      run_op(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 0, 8'h00);   // ALU write
      run_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 2, 8'h3C);   // load, 2 waits
      run_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 1, 8'h5A);   // data in first wait cycle

      // stray memory data while idle must be ignored
      @(negedge clk);
      mem_rd_valid = 1'b1;
      mem_rd_data  = 8'hEE;
      @(posedge clk); #1;
      idle_check("stray_valid");
      @(negedge clk);
      mem_rd_valid = 1'b0;

      run_op(1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 3, 8'h22);   // simultaneous, same reg
      chk("simul_final_r5", 32'(tb_rf[5]), 32'h22);
      run_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd8, int'(TO), 8'h81);  // valid in timeout cycle
      chk("valid_wins_no_err", 32'(bus_err), 32'd0);
      run_op(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, int'(TO) + 1, 8'h42);  // timeout
      run_op(1'b1, 4'd4, 8'h6D, 1'b0, 4'd0, 0, 8'h00);   // ALU after error
      chk("err_sticky", 32'(bus_err), 32'd1);

`ifdef REG_WB_FWD_EN
      @(negedge clk);
      dec_addr_x = 4'd5;
      dec_addr_y = 4'd2;
      alu_valid  = 1'b1;
      alu_addr   = 4'd2;
      alu_data   = 8'h99;
      @(posedge clk); #1;
      chk("fwd_y",    32'(fwd_y), 32'd1);
      chk("fwd_x",    32'(fwd_x), 32'd0);
      chk("fwd_data", 32'(fwd_data), 32'h99);
      model_rf[2] = 8'h99;
      @(negedge clk);
      alu_valid = 1'b0;
      @(posedge clk); #1;
      chk("fwd_y_off", 32'(fwd_y), 32'd0);
`endif

      // randomized transactions
      for (int i = 0; i < 24; i++) begin
         typ = $urandom_range(0, 2);
         w   = $urandom_range(1, 7);
         run_op(typ != 1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                typ != 0, 4'($urandom_range(0, 15)), w, 8'($urandom_range(0, 255)));
      end
      for (int r = 0; r < 16; r++) chk("rf_sweep", 32'(tb_rf[r]), 32'(model_rf[r]));

      // reset in the middle of a load
      @(negedge clk);
      ld_start = 1'b1;
      ld_addr  = 4'd9;
      @(posedge clk); #1;
      chk("mid_ld_stall", 32'(stall), 32'd1);
      @(negedge clk);
      ld_start   = 1'b0;
      dec_addr_x = 4'd0;
      rst_n      = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_we",    32'(rf_write_en), 32'd0);
      chk("mid_rst_data",  32'(rf_wr_data_x), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_err",   32'(bus_err), 32'd0);
      chk("mid_rst_addr",  32'(rf_addr_x), 32'd0);
      chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rd_valid = 1'b1;
      mem_rd_data  = 8'h77;
      @(posedge clk); #1;
      idle_check("post_rst_valid");
      @(negedge clk);
      mem_rd_valid = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_no_write", 32'(tb_rf[9]), 32'(model_rf[9]));
      run_op(1'b1, 4'd1, 8'hC3, 1'b0, 4'd0, 0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-back controller sitting directly upstream of the 16 x 8 register file.
- Owns the register file's shared X address, write enable and write data.
- Sequences ALU results (single cycle) and data-memory loads (variable wait states with timeout) into the register file.
- Stalls the decode stage while the X port is taken for a write or a load is outstanding.

Parameters:
- LOAD_TIMEOUT, 15, maximum cycles in LD_WAIT before abort; 0 disables the timeout; legal range 0..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dec_addr_x  in  4  decoder's X read address, used when no write is in progress.
- alu_valid  in  1  ALU result valid (single-cycle pulse).
- alu_addr  in  4  destination register of the ALU result.
- alu_data  in  8  ALU result.
- ld_start  in  1  load issued to data memory (single-cycle pulse).
- ld_addr  in  4  destination register of the load.
- mem_rd_valid  in  1  memory read data valid.
- mem_rd_data  in  8  memory read data.
- rf_addr_x  out  4  to reg_file addr_x.
- rf_write_en  out  1  to reg_file write_en (registered).
- rf_wr_data_x  out  8  to reg_file wr_data_x (registered).
- stall  out  1  decode/fetch hold request.
- bus_err  out  1  sticky load-timeout flag.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; rf_write_en=0, rf_wr_data_x=0, wb_addr=0, wait counter=0, bus_err=0.
  - Reset mid-operation abandons any pending write or load; no register-file write occurs.
- rf_addr_x = wb_addr when rf_write_en=1, otherwise dec_addr_x. This mux is the only combinational path.
- stall = rf_write_en OR (state==LD_WAIT).
- States:
  - IDLE, accepting requests:
    - alu_valid=1 in cycle N: rf_write_en=1, wb_addr=alu_addr, rf_wr_data_x=alu_data in cycle N+1 (latency 1). Stay IDLE.
    - ld_start=1: latch ld_addr into ld_dst, clear counter, go LD_WAIT.
    - Both in the same cycle: ALU write proceeds in N+1 and the FSM enters LD_WAIT in parallel. If addresses match, the load's later write wins.
  - LD_WAIT:
    - Counter increments each cycle.
    - mem_rd_valid=1: capture mem_rd_data, go WB. Accepted even in the first LD_WAIT cycle.
    - If LOAD_TIMEOUT!=0 and counter reaches LOAD_TIMEOUT without valid: set bus_err, go IDLE, no write.
    - mem_rd_valid and timeout in the same cycle: valid wins, no error.
  - WB: one cycle, then IDLE.
    - rf_write_en=1 with wb_addr=ld_dst and captured data, driven in the cycle after mem_rd_valid.
    - A new ld_start or alu_valid may be accepted in the cycle after WB.
- alu_valid or ld_start while state!=IDLE: ignored. Upstream is stalled, so this is a protocol violation; the bench flags it.
- mem_rd_valid outside LD_WAIT: ignored.
- bus_err is cleared only by reset.
- Counter width: 8 bits, saturating.

Optional Feature:
- Macro: REG_WB_FWD_EN.
- Defined: adds inputs dec_addr_y[3:0] and outputs fwd_x, fwd_y (1 bit each) plus fwd_data[7:0].
  - fwd_x/fwd_y = rf_write_en AND (wb_addr == dec_addr_x / dec_addr_y).
  - fwd_data = rf_wr_data_x.
  - Lets the operand stage bypass the value being written this cycle.
  - stall is unchanged.
- Undefined: these ports and this logic are absent.

Decomposition:
- Package minirisc_pkg holds:
  - REG_ADDR_W=4 and DATA_W=8 constants.
  - wb_state_t enum {IDLE, LD_WAIT, WB}.
- One natural sub-module, reg_wb_timeout_cnt: saturating 8-bit counter with clear, enable, and match against LOAD_TIMEOUT.

Test Plan:
- ALU write: alu_valid with addr=3, data=0xA5 in cycle 10 -> cycle 11 rf_write_en=1, rf_addr_x=3, rf_wr_data_x=0xA5, stall=1; cycle 12 rf_addr_x=dec_addr_x, stall=0.
- Load with 2 wait states: ld_start with addr=7, mem_rd_valid with 0x3C two cycles later -> stall high throughout; write of 0x3C to r7 in the following cycle; IDLE after.
- Timeout: LOAD_TIMEOUT=4, no mem_rd_valid -> bus_err=1 after 4 LD_WAIT cycles, no write, return IDLE; a later ALU write still works and bus_err stays 1.
- Simultaneous: alu_valid (r5, 0x11) and ld_start (r5) in the same cycle, then data 0x22 -> r5 written 0x11 then 0x22; final read of r5 gives 0x22.
- Reset mid-load: rst_n low during LD_WAIT, then mem_rd_valid -> no write, state IDLE, all outputs zero.
- REG_WB_FWD_EN: write r2=0x99 while dec_addr_y=2 -> fwd_y=1, fwd_data=0x99, fwd_x=0 when dec_addr_x≠2.
